predictor_update_ctrl: RTL and testbench

- Sequences all writes into the branch predictor tables (tag table, target buffer, 2-bit BHT), which have a single write port.
- After reset or flush, runs an index-by-index clear sweep.
- During normal operation, arbitrates queued tag/target installs from ID against BHT outcome updates from EX.
- Performs the BHT saturating-counter read-modify-write itself; the tables become plain storage.

---
 rtl/predictor_update_ctrl_pkg.sv | 26 ++
 rtl/pred_req_fifo.sv | 51 +++++
 rtl/predictor_update_ctrl.sv | 156 +++++++++++++++
 tb/tb_predictor_update_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/predictor_update_ctrl_pkg.sv
// Shared constants for the branch predictor update controller:
// default word size, 2-bit BHT counter encodings, FSM state encoding
// and the saturating counter step used by the BHT read-modify-write.
package predictor_update_ctrl_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
    if (taken) begin
      return (cur == STRONG_T) ? STRONG_T : cur + 2'b01;
    end
    return (cur == STRONG_NT) ? STRONG_NT : cur - 2'b01;
  endfunction

endpackage

// File: rtl/pred_req_fifo.sv
// Small synchronous request FIFO with a synchronous flush.
// DEPTH must be a power of two (>= 2); pointers carry one extra wrap bit
// so full/empty are told apart without a separate count.
// A push is only taken when the queue is not full at the start of the
// cycle, so push-and-pop on a full queue drops the push (caller gates
// push with its ready anyway).
module pred_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/predictor_update_ctrl.sv
// Single-write-port sequencer for the branch predictor tables.
// After reset/flush it clears every index (tag=0, target=0, BHT=weakly
// taken), then arbitrates queued BHT outcome updates (older, so first)
// against queued tag/target installs, doing the BHT counter RMW itself.
// Handshake: a request is accepted on the cycle where valid && ready are
// both high; ready never depends on valid, and accepted requests reach
// the tables no earlier than the following cycle.
// Optional build macro PREDICTOR_UPDATE_STATS_EN adds saturating
// install / BHT-update / stall counters.
module predictor_update_ctrl #(
  parameter int WORD_SIZE    = predictor_update_ctrl_pkg::WORD_SIZE,
  parameter int BTB_IDX_SIZE = 8,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          tag_req_valid,
  output logic                          tag_req_ready,
  input  logic [WORD_SIZE-1:0]          tag_req_pc,
  input  logic [WORD_SIZE-1:0]          tag_req_target,
  input  logic                          bht_req_valid,
  output logic                          bht_req_ready,
  input  logic [WORD_SIZE-1:0]          bht_req_pc,
  input  logic                          bht_req_taken,
  output logic [BTB_IDX_SIZE-1:0]       bht_rd_idx,
  input  logic [1:0]                    bht_rd_data,
  output logic                          tbl_we_tag,
  output logic                          tbl_we_bht,
  output logic [BTB_IDX_SIZE-1:0]       tbl_idx,
  output logic [WORD_SIZE-BTB_IDX_SIZE-1:0] tbl_tag,
  output logic [WORD_SIZE-1:0]          tbl_target,
  output logic [1:0]                    tbl_bht,
`ifdef PREDICTOR_UPDATE_STATS_EN
  output logic [15:0]                   stat_installs,
  output logic [15:0]                   stat_bht_updates,
  output logic [15:0]                   stat_stall_cycles,
`endif
  output logic                          init_busy,
  output logic                          dbg_state
);

  import predictor_update_ctrl_pkg::*;

  localparam int IDX   = BTB_IDX_SIZE;
  localparam int TAG_W = 2 * WORD_SIZE;
  localparam int BHT_W = IDX + 1;

  state_t           state;
  logic [IDX-1:0]   sweep_cnt;

  logic             tag_empty, tag_full, bht_empty, bht_full;
  logic [TAG_W-1:0] tag_head;
  logic [BHT_W-1:0] bht_head;
  logic             tag_push, bht_push, tag_pop, bht_pop;
  logic             do_bht, do_tag;

  logic [WORD_SIZE-1:0] head_pc;
  logic [IDX-1:0]       head_bht_idx;
  logic                 head_taken;

  assign head_pc      = tag_head[TAG_W-1:WORD_SIZE];
  assign head_bht_idx = bht_head[BHT_W-1:1];
  assign head_taken   = bht_head[0];

  assign tag_req_ready = (state == ST_RUN) && !flush && !tag_full;
  assign bht_req_ready = (state == ST_RUN) && !flush && !bht_full;
  assign tag_push      = tag_req_valid && tag_req_ready;
  assign bht_push      = bht_req_valid && bht_req_ready;

  assign do_bht  = (state == ST_RUN) && !flush && !reset && !bht_empty;
  assign do_tag  = (state == ST_RUN) && !flush && !reset && bht_empty && !tag_empty;
  assign bht_pop = do_bht;
  assign tag_pop = do_tag;

  assign init_busy  = (state == ST_INIT);
  assign dbg_state  = state;
  assign bht_rd_idx = head_bht_idx;

  pred_req_fifo #(.WIDTH(TAG_W), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk(clk), .rst(reset), .flush(flush),
    .push(tag_push), .push_data({tag_req_pc, tag_req_target}),
    .pop(tag_pop), .head(tag_head), .empty(tag_empty), .full(tag_full)
  );

  pred_req_fifo #(.WIDTH(BHT_W), .DEPTH(FIFO_DEPTH)) u_bht_q (
    .clk(clk), .rst(reset), .flush(flush),
    .push(bht_push), .push_data({bht_req_pc[IDX-1:0], bht_req_taken}),
    .pop(bht_pop), .head(bht_head), .empty(bht_empty), .full(bht_full)
  );

  // Sweep/run state; flush or reset restarts the clear sweep at index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else if (flush) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_cnt <= sweep_cnt + IDX'(1);
          if (sweep_cnt == '1) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Table write port: sweep clear, BHT RMW, or tag install.
  always_comb begin
    tbl_we_tag = 1'b0;
    tbl_we_bht = 1'b0;
    tbl_idx    = sweep_cnt;
    tbl_tag    = '0;
    tbl_target = '0;
    tbl_bht    = WEAK_T;
    if (state == ST_INIT) begin
      tbl_we_tag = !flush && !reset;
      tbl_we_bht = !flush && !reset;
    end else if (do_bht) begin
      tbl_we_bht = 1'b1;
      tbl_idx    = head_bht_idx;
      tbl_bht    = bht_next(bht_rd_data, head_taken);
    end else if (do_tag) begin
      tbl_we_tag = 1'b1;
      tbl_we_bht = 1'b1;
      tbl_idx    = head_pc[IDX-1:0];
      tbl_tag    = head_pc[WORD_SIZE-1:IDX];
      tbl_target = tag_head[WORD_SIZE-1:0];
    end
  end

`ifdef PREDICTOR_UPDATE_STATS_EN
  // Saturating activity counters, cleared by reset and flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_installs     <= '0;
      stat_bht_updates  <= '0;
      stat_stall_cycles <= '0;
    end else if (flush) begin
      stat_installs     <= '0;
      stat_bht_updates  <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (do_tag && stat_installs != 16'hFFFF) stat_installs <= stat_installs + 16'd1;
      if (do_bht && stat_bht_updates != 16'hFFFF) stat_bht_updates <= stat_bht_updates + 16'd1;
      if (((tag_req_valid && !tag_req_ready) || (bht_req_valid && !bht_req_ready)) &&
          stat_stall_cycles != 16'hFFFF)
        stat_stall_cycles <= stat_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_predictor_update_ctrl.sv
// Directed bench for predictor_update_ctrl with BTB_IDX_SIZE = 4.
module tb_predictor_update_ctrl;

  localparam int W   = 16;
  localparam int IDX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          tag_req_valid = 1'b0;
  logic          tag_req_ready;
  logic [W-1:0]  tag_req_pc = '0;
  logic [W-1:0]  tag_req_target = '0;
  logic          bht_req_valid = 1'b0;
  logic          bht_req_ready;
  logic [W-1:0]  bht_req_pc = '0;
  logic          bht_req_taken = 1'b0;
  logic [IDX-1:0] bht_rd_idx;
  logic [1:0]    bht_rd_data = 2'b00;
  logic          tbl_we_tag, tbl_we_bht;
  logic [IDX-1:0] tbl_idx;
  logic [W-IDX-1:0] tbl_tag;
  logic [W-1:0]  tbl_target;
  logic [1:0]    tbl_bht;
  logic          init_busy;
  logic          dbg_state;
`ifdef PREDICTOR_UPDATE_STATS_EN
  logic [15:0]   stat_installs, stat_bht_updates, stat_stall_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  predictor_update_ctrl #(.WORD_SIZE(W), .BTB_IDX_SIZE(IDX), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .tag_req_valid(tag_req_valid), .tag_req_ready(tag_req_ready),
    .tag_req_pc(tag_req_pc), .tag_req_target(tag_req_target),
    .bht_req_valid(bht_req_valid), .bht_req_ready(bht_req_ready),
    .bht_req_pc(bht_req_pc), .bht_req_taken(bht_req_taken),
    .bht_rd_idx(bht_rd_idx), .bht_rd_data(bht_rd_data),
    .tbl_we_tag(tbl_we_tag), .tbl_we_bht(tbl_we_bht), .tbl_idx(tbl_idx),
    .tbl_tag(tbl_tag), .tbl_target(tbl_target), .tbl_bht(tbl_bht),
`ifdef PREDICTOR_UPDATE_STATS_EN
    .stat_installs(stat_installs), .stat_bht_updates(stat_bht_updates),
    .stat_stall_cycles(stat_stall_cycles),
`endif
    .init_busy(init_busy), .dbg_state(dbg_state)
  );

  // Clock: posedge at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_we_tag"}, tbl_we_tag, 0);
    chk({tag, "_we_bht"}, tbl_we_bht, 0);
  endtask

  task automatic chk_run_ready(input string tag);
    #1;
    chk({tag, "_busy"}, init_busy, 0);
    chk({tag, "_tag_rdy"}, tag_req_ready, 1);
    chk({tag, "_bht_rdy"}, bht_req_ready, 1);
    chk({tag, "_we_tag"}, tbl_we_tag, 0);
    chk({tag, "_we_bht"}, tbl_we_bht, 0);
  endtask

  // Checks n sweep cycles starting at index 0, leaving time after the last edge.
  task automatic chk_sweep(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_we_tag"}, tbl_we_tag, 1);
      chk({tag, "_we_bht"}, tbl_we_bht, 1);
      chk({tag, "_idx"}, tbl_idx, i);
      chk({tag, "_bht"}, tbl_bht, 2'b10);
      chk({tag, "_tagd"}, tbl_tag, 0);
      chk({tag, "_tgt"}, tbl_target, 0);
      chk({tag, "_busy"}, init_busy, 1);
      chk({tag, "_rdy"}, {tag_req_ready, bht_req_ready}, 2'b00);
      tick();
    end
  endtask

  // One BHT update, then the RMW result in the following cycle.
  task automatic bht_one(input string tag, input logic [W-1:0] pc, input logic taken,
                         input logic [1:0] rd, input logic [1:0] exp);
    bht_req_valid = 1'b1; bht_req_pc = pc; bht_req_taken = taken; bht_rd_data = rd;
    tick();
    bht_req_valid = 1'b0;
    #1;
    chk({tag, "_rd_idx"}, bht_rd_idx, pc[IDX-1:0]);
    chk({tag, "_we_bht"}, tbl_we_bht, 1);
    chk({tag, "_we_tag"}, tbl_we_tag, 0);
    chk({tag, "_idx"}, tbl_idx, pc[IDX-1:0]);
    chk({tag, "_bht"}, tbl_bht, exp);
    tick();
  endtask

  initial begin
    // Reset asserted: no writes, no readies, sweep reported busy.
    #1 reset = 1'b1;
    #1;
    chk("rst_we", {tbl_we_tag, tbl_we_bht}, 2'b00);
    chk("rst_rdy", {tag_req_ready, bht_req_ready}, 2'b00);
    chk("rst_busy", init_busy, 1);
    repeat (3) tick();
    reset = 1'b0;
    chk_sweep("sweep0", 16);
    chk_run_ready("run0");

    // Tag install: pc 0x0123 -> idx 3, tag 0x012.
    tick();
    tag_req_valid = 1'b1; tag_req_pc = 16'h0123; tag_req_target = 16'h0456;
    #1 chk("inst_rdy", tag_req_ready, 1);
    chk("inst_no_bypass", tbl_we_tag, 0);
    tick();
    tag_req_valid = 1'b0;
    #1;
    chk("inst_we_tag", tbl_we_tag, 1);
    chk("inst_we_bht", tbl_we_bht, 1);
    chk("inst_idx", tbl_idx, 4'h3);
    chk("inst_tag", tbl_tag, 12'h012);
    chk("inst_tgt", tbl_target, 16'h0456);
    chk("inst_bht", tbl_bht, 2'b10);
    tick();
    chk_idle("inst_after");

    // BHT read-modify-write including both saturation limits.
    tick();
    bht_one("bht_t_sat", 16'h0005, 1'b1, 2'b11, 2'b11);
    bht_one("bht_nt_sat", 16'h0005, 1'b0, 2'b00, 2'b00);
    bht_one("bht_t_inc", 16'h000C, 1'b1, 2'b01, 2'b10);
    bht_one("bht_nt_dec", 16'h00F2, 1'b0, 2'b10, 2'b01);

    // Same-cycle requests: BHT (idx 9) wins, tag (idx 7) follows.
    tag_req_valid = 1'b1; tag_req_pc = 16'h0A07; tag_req_target = 16'h1234;
    bht_req_valid = 1'b1; bht_req_pc = 16'h0309; bht_req_taken = 1'b1; bht_rd_data = 2'b01;
    tick();
    tag_req_valid = 1'b0; bht_req_valid = 1'b0;
    #1;
    chk("arb1_we", {tbl_we_tag, tbl_we_bht}, 2'b01);
    chk("arb1_idx", tbl_idx, 4'h9);
    chk("arb1_bht", tbl_bht, 2'b10);
    tick();
    #1;
    chk("arb2_we", {tbl_we_tag, tbl_we_bht}, 2'b11);
    chk("arb2_idx", tbl_idx, 4'h7);
    chk("arb2_tag", tbl_tag, 12'h0A0);
    chk("arb2_tgt", tbl_target, 16'h1234);
    tick();
    chk_idle("arb_after");

    // Tag queue fills to 2 behind a BHT stream; third install is refused.
    bht_rd_data = 2'b00;
    tick();
    tag_req_valid = 1'b1; tag_req_pc = 16'h1111; tag_req_target = 16'hA001;
    bht_req_valid = 1'b1; bht_req_pc = 16'h0004; bht_req_taken = 1'b1;
    #1 chk("fill_a_rdy", {tag_req_ready, bht_req_ready}, 2'b11);
    tick();
    tag_req_pc = 16'h2222; tag_req_target = 16'hA002;
    bht_req_pc = 16'h0008;
    #1;
    chk("fill_b_rdy", {tag_req_ready, bht_req_ready}, 2'b11);
    chk("fill_b_we", {tbl_we_tag, tbl_we_bht}, 2'b01);
    chk("fill_b_idx", tbl_idx, 4'h4);
    tick();
    tag_req_pc = 16'h3333; tag_req_target = 16'hA003;
    bht_req_valid = 1'b0;
    #1;
    chk("fill_c_tag_rdy", tag_req_ready, 0);
    chk("fill_c_we", {tbl_we_tag, tbl_we_bht}, 2'b01);
    chk("fill_c_idx", tbl_idx, 4'h8);
    chk("fill_c_bht", tbl_bht, 2'b01);
    tick();
    tag_req_valid = 1'b0;
    #1;
    chk("drain1_we", {tbl_we_tag, tbl_we_bht}, 2'b11);
    chk("drain1_idx", tbl_idx, 4'h1);
    chk("drain1_tgt", tbl_target, 16'hA001);
    tick();
    #1;
    chk("drain2_we", {tbl_we_tag, tbl_we_bht}, 2'b11);
    chk("drain2_idx", tbl_idx, 4'h2);
    chk("drain2_tag", tbl_tag, 12'h222);
    tick();
    chk_idle("drain3");

    // Flush with both queues holding a request, then a flush mid-sweep.
    tick();
    tag_req_valid = 1'b1; tag_req_pc = 16'h00AA; tag_req_target = 16'hBEEF;
    bht_req_valid = 1'b1; bht_req_pc = 16'h00BB; bht_req_taken = 1'b1;
    tick();
    tag_req_valid = 1'b0; bht_req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl1_we", {tbl_we_tag, tbl_we_bht}, 2'b00);
    chk("fl1_rdy", {tag_req_ready, bht_req_ready}, 2'b00);
    tick();
    flush = 1'b0;
    chk_sweep("sweep_pre", 6);
    flush = 1'b1;
    #1;
    chk("fl2_we", {tbl_we_tag, tbl_we_bht}, 2'b00);
    chk("fl2_busy", init_busy, 1);
    chk("fl2_rdy", {tag_req_ready, bht_req_ready}, 2'b00);
    tick();
    flush = 1'b0;
    chk_sweep("sweep_fl", 16);
    chk_run_ready("run_fl");
    tick();
    chk_idle("fl_discarded");

    // Asynchronous reset between edges while a tag write is in flight.
    tick();
    tag_req_valid = 1'b1; tag_req_pc = 16'h0F0E; tag_req_target = 16'h5555;
    tick();
    tag_req_valid = 1'b0;
    #1 chk("ar_pre_we", tbl_we_tag, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_we", {tbl_we_tag, tbl_we_bht}, 2'b00);
    chk("ar_rdy", {tag_req_ready, bht_req_ready}, 2'b00);
    chk("ar_busy", init_busy, 1);
    tick();
    tick();
    reset = 1'b0;
    chk_sweep("sweep_ar", 16);
    chk_run_ready("run_ar");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
